rotary_value_accum: RTL and testbench

Downstream consumer of the rotary order scanner's one-cycle o_cw/o_ccw step pulses. Maintains a bounded parameter value (strobe rate, brightness, etc.) for the HUB75/strobe control logic. Accelerates when steps arrive quickly in the same direction. Supports a synchronous load.

---
 rtl/rotary_value_accum.sv | 154 +++++++++++++++
 tb/tb_rotary_value_accum.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rotary_value_accum.sv
// Bounded value accumulator driven by rotary step pulses, with streak-based acceleration.
// Define ROTARY_WRAP_EN to wrap out-of-range results instead of saturating at the bounds.
module rotary_value_accum #(
   parameter int WIDTH       = 8,
   parameter int MIN_VAL     = 0,
   parameter int MAX_VAL     = 255,
   parameter int INIT_VAL    = 128,
   parameter int TIMER_W     = 22,
   parameter int FAST_WINDOW = 2000000,
   parameter int FAST_COUNT  = 3,
   parameter int FAST_STEP   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_cw,
   input  logic             i_ccw,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] value,
   output logic             o_changed,
   output logic             o_fast,
   output logic             o_limit
);

   localparam int SW = $clog2(FAST_COUNT + 1);
   localparam logic [WIDTH:0]   MIN_X      = (WIDTH+1)'(MIN_VAL);
   localparam logic [WIDTH:0]   MAX_X      = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH:0]   FSTEP_X    = (WIDTH+1)'(FAST_STEP);
   localparam logic [WIDTH-1:0] INIT_W     = WIDTH'(INIT_VAL);
   localparam logic [TIMER_W-1:0] WIN_LOAD = TIMER_W'(FAST_WINDOW - 1);
   localparam logic [SW-1:0]    FC_S       = SW'(FAST_COUNT);
`ifdef ROTARY_WRAP_EN
   localparam logic [WIDTH:0]   RANGE_X    = (WIDTH+1)'(MAX_VAL - MIN_VAL + 1);
`endif

   typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;

   state_t             state_q, state_d;
   logic               dir_q, dir_d;
   logic [SW-1:0]      streak_q, streak_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [WIDTH-1:0]   value_q, value_d;
   logic               changed_q, changed_d;
   logic               limit_q, limit_d;
   logic [WIDTH:0]     ext_v, size, nv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         dir_q     <= 1'b0;
         streak_q  <= '0;
         timer_q   <= '0;
         value_q   <= INIT_W;
         changed_q <= 1'b0;
         limit_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         streak_q  <= streak_d;
         timer_q   <= timer_d;
         value_q   <= value_d;
         changed_q <= changed_d;
         limit_q   <= limit_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      streak_d  = streak_q;
      timer_d   = timer_q;
      value_d   = value_q;
      changed_d = 1'b0;
      limit_d   = 1'b0;
      ext_v     = {1'b0, value_q};
      size      = (WIDTH+1)'(1);
      nv        = ext_v;
      if (load) begin
         if ({1'b0, load_val} > MAX_X)      value_d = MAX_X[WIDTH-1:0];
         else if ({1'b0, load_val} < MIN_X) value_d = MIN_X[WIDTH-1:0];
         else                               value_d = load_val;
         state_d   = IDLE;
         streak_d  = '0;
         timer_d   = '0;
         changed_d = (value_d != value_q);
      end else if (i_cw ^ i_ccw) begin
         timer_d = WIN_LOAD;
         dir_d   = i_cw;
         case (state_q)
            IDLE: begin
               state_d  = SLOW;
               streak_d = SW'(1);
            end
            SLOW: begin
               if (i_cw == dir_q) begin
                  if (streak_q < FC_S) streak_d = streak_q + SW'(1);
                  if (streak_d >= FC_S) state_d = FAST;
               end else begin
                  streak_d = SW'(1);
               end
            end
            FAST: begin
               if (i_cw == dir_q) begin
                  size = FSTEP_X;
               end else begin
                  state_d  = SLOW;
                  streak_d = SW'(1);
               end
            end
            default: begin
               state_d  = IDLE;
               streak_d = '0;
            end
         endcase
         // Arithmetic is one bit wider than value so nothing wraps before the bound test.
         if (i_cw) begin
            nv = ext_v + size;
            if (nv > MAX_X) begin
               limit_d = 1'b1;
`ifdef ROTARY_WRAP_EN
               nv = nv - RANGE_X;
`else
               nv = MAX_X;
`endif
            end
         end else begin
            if (ext_v < MIN_X + size) begin
               limit_d = 1'b1;
`ifdef ROTARY_WRAP_EN
               nv = ext_v + RANGE_X - size;
`else
               nv = MIN_X;
`endif
            end else begin
               nv = ext_v - size;
            end
         end
         value_d   = nv[WIDTH-1:0];
         changed_d = (value_d != value_q);
      end else if (!(i_cw && i_ccw) && (timer_q != '0)) begin
         timer_d = timer_q - TIMER_W'(1);
         if ((timer_q == TIMER_W'(1)) && (state_q != IDLE)) begin
            state_d  = IDLE;
            streak_d = '0;
         end
      end
   end

   assign value     = value_q;
   assign o_changed = changed_q;
   assign o_limit   = limit_q;
   assign o_fast    = (state_q == FAST);

endmodule

// File: tb/tb_rotary_value_accum.sv
// Randomized scoreboard bench for rotary_value_accum against a streak/window reference model.
module tb_rotary_value_accum;

   localparam int W     = 8;
   localparam int MINV  = 10;
   localparam int MAXV  = 200;
   localparam int INITV = 128;
   localparam int TW    = 8;
   localparam int FW    = 40;
   localparam int FC    = 3;
   localparam int FS    = 8;
   localparam int EW    = W + 3;
   localparam int RNG   = MAXV - MINV + 1;
`ifdef ROTARY_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         i_cw = 1'b0, i_ccw = 1'b0, load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] value;
   logic         o_changed, o_fast, o_limit;

   int n_tests = 0;
   int n_fail  = 0;
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] mon_exp, mon_got;

   // Reference model: current value, streak length, last direction, idle cycles since last step.
   int m_val = INITV;
   int m_s = 0;
   int m_d = 0;
   int m_idle = 0;

   always #5 clk = ~clk;

   rotary_value_accum #(
      .WIDTH(W), .MIN_VAL(MINV), .MAX_VAL(MAXV), .INIT_VAL(INITV), .TIMER_W(TW),
      .FAST_WINDOW(FW), .FAST_COUNT(FC), .FAST_STEP(FS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_cw(i_cw), .i_ccw(i_ccw), .load(load),
      .load_val(load_val), .value(value), .o_changed(o_changed), .o_fast(o_fast),
      .o_limit(o_limit)
   );

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int clampv(input int v);
      if (v > MAXV) return MAXV;
      if (v < MINV) return MINV;
      return v;
   endfunction

   task automatic drive(input bit cw, input bit ccw, input bit ld, input int lv);
      int  size, nv;
      bit  lim, chg, fast;
      @(negedge clk);
      i_cw = cw; i_ccw = ccw; load = ld; load_val = W'(lv);
      lim = 1'b0;
      nv = m_val;
      if (ld) begin
         nv = clampv(lv);
         m_s = 0;
         m_idle = 0;
      end else if (cw != ccw) begin
         if (m_s == 0 || m_idle >= FW - 1 || int'(cw) != m_d) begin
            m_s = 1;
            size = 1;
         end else if (m_s >= FC) begin
            size = FS;
         end else begin
            m_s++;
            size = 1;
         end
         m_d = int'(cw);
         m_idle = 0;
         nv = cw ? m_val + size : m_val - size;
         if (nv > MAXV) begin
            lim = 1'b1;
            nv = WRAP ? nv - RNG : MAXV;
         end else if (nv < MINV) begin
            lim = 1'b1;
            nv = WRAP ? nv + RNG : MINV;
         end
      end else if (!cw) begin
         if (m_idle < 1000) m_idle++;
      end
      chg = (nv != m_val);
      m_val = nv;
      fast = (m_s >= FC) && (m_idle < FW - 1);
      exp_q.push_back({W'(m_val), chg, lim, fast});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic async_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      i_cw = 1'b0; i_ccw = 1'b0; load = 1'b0;
      #1;
      check("rst_value", int'(value), INITV);
      check("rst_fast", int'(o_fast), 0);
      check("rst_changed", int'(o_changed), 0);
      check("rst_limit", int'(o_limit), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      m_val = INITV; m_s = 0; m_d = 0; m_idle = 0;
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_got = {value, o_changed, o_limit, o_fast};
         n_tests++;
         if (mon_got !== mon_exp) begin
            n_fail++;
            $display("FAIL out_cycle @%0t: got value=%0d chg=%b lim=%b fast=%b, expected value=%0d chg=%b lim=%b fast=%b",
                     $time, mon_got[EW-1:3], mon_got[2], mon_got[1], mon_got[0],
                     mon_exp[EW-1:3], mon_exp[2], mon_exp[1], mon_exp[0]);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bit pref;
      int r;
      #1 rst_n = 1'b0;
      #1;
      check("init_value", int'(value), INITV);
      check("init_fast", int'(o_fast), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Slow steps spaced beyond the window.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b0, 0);
         idle(FW + 10);
      end
      // Acceleration, direction reversal, window expiry.
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 1'b0, 0);
         idle(9);
      end
      drive(1'b0, 1'b1, 1'b0, 0);
      idle(FW + 5);
      drive(1'b1, 1'b0, 1'b0, 0);
      // Saturation at the top, load clamping, floor.
      drive(1'b0, 1'b0, 1'b1, 195);
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b0, 1'b0, 0);
         idle(1);
      end
      drive(1'b0, 1'b0, 1'b1, 250);
      drive(1'b0, 1'b0, 1'b1, 3);
      drive(1'b0, 1'b1, 1'b0, 0);
      drive(1'b0, 1'b0, 1'b1, 13);
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 0);
      // Simultaneous events.
      drive(1'b1, 1'b1, 1'b0, 0);
      drive(1'b1, 1'b1, 1'b0, 0);
      drive(1'b1, 1'b0, 1'b1, 77);
      drive(1'b1, 1'b0, 1'b0, 0);
      // Reset in the middle of a fast streak.
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 0);
      async_reset();

      pref = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         if (i == 1500) async_reset();
         if (r < 4) begin
            drive(1'b0, 1'b0, 1'b1, $urandom_range(0, 255));
         end else if (r < 7) begin
            drive(1'b1, 1'b1, 1'b0, 0);
         end else if (r < 55) begin
            if ($urandom_range(0, 9) == 0) pref = ~pref;
            drive(pref, ~pref, 1'b0, 0);
         end else if (r < 58) begin
            idle($urandom_range(FW - 3, FW + 3));
         end else begin
            idle($urandom_range(0, 12));
         end
      end

      idle(3);
      @(posedge clk);
      #2;
      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
